// File: rtl/lsu_ctrl_if.sv
// Memory request bus between the load/store controller and data memory.
// master: drives mem_req/mem_we/mem_be, samples mem_ack; slave is the mirror.
interface lsu_ctrl_if;
  logic       mem_req;
  logic       mem_we;
  logic [3:0] mem_be;
  logic       mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_be,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_be,
    output mem_ack
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store control FSM: decodes LOAD/STORE, checks func3 and alignment,
// issues one memory request with timeout, raises ld_wr or a fault pulse.
// Ports: clk, rst (async active-low), inst_valid/opcode/func3/addr_lo
// (decode), mem (request bus, master), ld_func3, ld_wr, stall, fault,
// fault_cause.
module lsu_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inst_valid,
  input  logic [4:0] opcode,
  input  logic [2:0] func3,
  input  logic [1:0] addr_lo,
  lsu_ctrl_if.master mem,
  output logic [2:0] ld_func3,
  output logic       ld_wr,
  output logic       stall,
  output logic       fault,
  output logic [1:0] fault_cause
);

  localparam logic [4:0] OP_LOAD  = 5'b00000;
  localparam logic [4:0] OP_STORE = 5'b01000;
  localparam logic [4:0] TO_LIM   = 5'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE,
    ERR
  } state_t;

  state_t     state;
  logic [4:0] cnt;
  logic [4:0] cnt_inc;

  logic       is_ld;
  logic       is_st;
  logic       accept;
  logic       illegal;
  logic       misal;
  logic [3:0] be_calc;

  always_comb begin
    is_ld   = (opcode == OP_LOAD);
    is_st   = (opcode == OP_STORE);
    accept  = (state == IDLE) & inst_valid & (is_ld | is_st);
    illegal = (is_ld & ((func3 == 3'b011) |
                        (func3 == 3'b110) |
                        (func3 == 3'b111)))
            | (is_st & (func3 > 3'b010));
    misal   = ((func3[1:0] == 2'b01) & addr_lo[0])
            | ((func3[1:0] == 2'b10) & (addr_lo != 2'b00));
    cnt_inc = cnt + 5'd1;
  end

  always_comb begin
    be_calc = 4'b0000;
    unique case (1'b1)
      func3[1:0] == 2'b00: be_calc = 4'b0001 << addr_lo;
      func3[1:0] == 2'b01: be_calc = addr_lo[1] ? 4'b1100 : 4'b0011;
      func3[1:0] == 2'b10: be_calc = 4'b1111;
      default:             be_calc = 4'b0000;
    endcase
  end

  // Reset gate keeps stall low while rst is held, even if an
  // accepting instruction sits at decode.
  assign stall = rst & (accept | (state == REQ));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= 5'd0;
      mem.mem_req <= 1'b0;
      mem.mem_we  <= 1'b0;
      mem.mem_be  <= 4'b0000;
      ld_func3    <= 3'b000;
      ld_wr       <= 1'b0;
      fault       <= 1'b0;
      fault_cause <= 2'b00;
    end else begin
      ld_wr       <= 1'b0;
      fault       <= 1'b0;
      fault_cause <= 2'b00;
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (illegal) begin
              state       <= ERR;
              fault       <= 1'b1;
              fault_cause <= 2'b10;
            end else if (misal) begin
              state       <= ERR;
              fault       <= 1'b1;
              fault_cause <= 2'b01;
            end else begin
              state       <= REQ;
              cnt         <= 5'd0;
              mem.mem_req <= 1'b1;
              mem.mem_we  <= is_st;
              mem.mem_be  <= be_calc;
              ld_func3    <= func3;
            end
          end
        end
        REQ: begin
          // Ack is checked before the limit so a last-cycle ack wins.
          if (mem.mem_ack) begin
            state       <= DONE;
            mem.mem_req <= 1'b0;
            mem.mem_we  <= 1'b0;
            mem.mem_be  <= 4'b0000;
            ld_wr       <= ~mem.mem_we;
          end else if (cnt_inc == TO_LIM) begin
            state       <= ERR;
            cnt         <= cnt_inc;
            mem.mem_req <= 1'b0;
            mem.mem_we  <= 1'b0;
            mem.mem_be  <= 4'b0000;
            ld_func3    <= 3'b000;
            fault       <= 1'b1;
            fault_cause <= 2'b11;
          end else begin
            cnt <= cnt_inc;
          end
        end
        DONE: begin
          state    <= IDLE;
          ld_func3 <= 3'b000;
        end
        ERR: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: vector table of single transactions
// plus hand sequences for reset, ignored inputs and stray acks.
module tb_lsu_ctrl;

  logic       clk;
  logic       rst;
  logic       inst_valid;
  logic [4:0] opcode;
  logic [2:0] func3;
  logic [1:0] addr_lo;
  logic [2:0] ld_func3;
  logic       ld_wr;
  logic       stall;
  logic       fault;
  logic [1:0] fault_cause;

  lsu_ctrl_if bus ();

  lsu_ctrl #(.TIMEOUT(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .inst_valid  (inst_valid),
    .opcode      (opcode),
    .func3       (func3),
    .addr_lo     (addr_lo),
    .mem         (bus.master),
    .ld_func3    (ld_func3),
    .ld_wr       (ld_wr),
    .stall       (stall),
    .fault       (fault),
    .fault_cause (fault_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [4:0] LD = 5'b00000;
  localparam logic [4:0] ST = 5'b01000;

  typedef struct {
    string      name;
    logic [4:0] op;
    logic [2:0] f3;
    logic [1:0] addr;
    int         ack_at;
    bit         noise;
    logic [3:0] exp_be;
    logic       exp_we;
    int         exp_req;
    int         exp_ldwr;
    int         exp_fault;
    logic [1:0] exp_cause;
    int         exp_stall;
  } vec_t;

  int checks;
  int errors;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t v);
    int         req_n;
    int         ld_cyc;
    int         f_cyc;
    int         st_n;
    int         be_bad;
    logic [3:0] be_seen;
    logic       we_seen;
    logic [1:0] cause_seen;
    logic [2:0] f3_seen;
    req_n = 0; ld_cyc = 0; f_cyc = 0; be_bad = 0;
    be_seen = 4'b0; we_seen = 1'b0;
    cause_seen = 2'b0; f3_seen = 3'b0;
    @(negedge clk);
    inst_valid = 1'b1;
    opcode     = v.op;
    func3      = v.f3;
    addr_lo    = v.addr;
    bus.mem_ack = 1'b0;
    #1;
    st_n = stall ? 1 : 0;
    for (int c = 1; c <= 22; c++) begin
      @(posedge clk);
      #1;
      if (stall) st_n++;
      if (ld_wr && ld_cyc == 0) begin
        ld_cyc  = c;
        f3_seen = ld_func3;
      end
      if (fault && f_cyc == 0) begin
        f_cyc      = c;
        cause_seen = fault_cause;
      end
      if (bus.mem_req) begin
        req_n++;
        if (req_n == 1) begin
          be_seen = bus.mem_be;
          we_seen = bus.mem_we;
        end else if (bus.mem_be != be_seen || bus.mem_we != we_seen) begin
          be_bad++;
        end
        bus.mem_ack = (req_n == v.ack_at);
        if (v.noise) begin
          inst_valid = 1'b1;
          opcode     = $urandom_range(1) ? LD : ST;
          func3      = 3'($urandom);
          addr_lo    = 2'($urandom);
        end else begin
          inst_valid = 1'b0;
        end
      end else begin
        bus.mem_ack = 1'b0;
        inst_valid  = 1'b0;
      end
    end
    bus.mem_ack = 1'b0;
    inst_valid  = 1'b0;
    chk({v.name, " req_cycles"}, req_n, v.exp_req);
    if (v.exp_req > 0) begin
      chk({v.name, " mem_be"}, int'(be_seen), int'(v.exp_be));
      chk({v.name, " mem_we"}, int'(we_seen), int'(v.exp_we));
      chk({v.name, " be_we_stable"}, be_bad, 0);
    end
    chk({v.name, " ld_wr_cycle"}, ld_cyc, v.exp_ldwr);
    if (v.exp_ldwr > 0)
      chk({v.name, " ld_func3"}, int'(f3_seen), int'(v.f3));
    chk({v.name, " fault_cycle"}, f_cyc, v.exp_fault);
    chk({v.name, " fault_cause"}, int'(cause_seen), int'(v.exp_cause));
    chk({v.name, " stall_cycles"}, st_n, v.exp_stall);
  endtask

  vec_t vecs[13];
  int   bad;

  initial begin
    checks = 0;
    errors = 0;
    vecs[0]  = '{"lw_a0",      LD, 3'b010, 2'd0, 1,  0, 4'b1111, 1'b0, 1,  2, 0,  2'b00, 2};
    vecs[1]  = '{"sb_a3",      ST, 3'b000, 2'd3, 3,  0, 4'b1000, 1'b1, 3,  0, 0,  2'b00, 4};
    vecs[2]  = '{"lh_mis",     LD, 3'b001, 2'd1, 1,  0, 4'b0000, 1'b0, 0,  0, 1,  2'b01, 1};
    vecs[3]  = '{"ld_f3_110",  LD, 3'b110, 2'd0, 1,  0, 4'b0000, 1'b0, 0,  0, 1,  2'b10, 1};
    vecs[4]  = '{"sw_timeout", ST, 3'b010, 2'd0, 0,  0, 4'b1111, 1'b1, 16, 0, 17, 2'b11, 17};
    vecs[5]  = '{"sw_ack16",   ST, 3'b010, 2'd0, 16, 0, 4'b1111, 1'b1, 16, 0, 0,  2'b00, 17};
    vecs[6]  = '{"sh_a2",      ST, 3'b001, 2'd2, 1,  0, 4'b1100, 1'b1, 1,  0, 0,  2'b00, 2};
    vecs[7]  = '{"lb_a1",      LD, 3'b000, 2'd1, 2,  0, 4'b0010, 1'b0, 2,  3, 0,  2'b00, 3};
    vecs[8]  = '{"lhu_a2",     LD, 3'b101, 2'd2, 1,  0, 4'b1100, 1'b0, 1,  2, 0,  2'b00, 2};
    vecs[9]  = '{"sw_mis",     ST, 3'b010, 2'd2, 1,  0, 4'b0000, 1'b0, 0,  0, 1,  2'b01, 1};
    vecs[10] = '{"st_f3_011",  ST, 3'b011, 2'd1, 1,  0, 4'b0000, 1'b0, 0,  0, 1,  2'b10, 1};
    vecs[11] = '{"ld_f3_111",  LD, 3'b111, 2'd3, 1,  0, 4'b0000, 1'b0, 0,  0, 1,  2'b10, 1};
    vecs[12] = '{"sb_noise",   ST, 3'b000, 2'd0, 4,  1, 4'b0001, 1'b1, 4,  0, 0,  2'b00, 5};

    // Reset with an accepting LOAD at decode: everything must stay 0.
    rst         = 1'b0;
    inst_valid  = 1'b1;
    opcode      = LD;
    func3       = 3'b010;
    addr_lo     = 2'd0;
    bus.mem_ack = 1'b0;
    #12;
    chk("reset_stall", int'(stall), 0);
    chk("reset_outs", int'({bus.mem_req, bus.mem_we, bus.mem_be,
                            ld_func3, ld_wr, fault, fault_cause}), 0);
    @(negedge clk);
    inst_valid = 1'b0;
    rst = 1'b1;

    foreach (vecs[i]) run(vecs[i]);

    // Non load/store opcode: no accept, nothing happens.
    @(negedge clk);
    inst_valid = 1'b1;
    opcode     = 5'b01100;
    func3      = 3'b010;
    addr_lo    = 2'd0;
    #1;
    chk("other_op_stall", int'(stall), 0);
    bad = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.mem_req || ld_wr || fault || stall) bad++;
    end
    chk("other_op_idle", bad, 0);
    inst_valid = 1'b0;

    // Stray ack while idle is ignored.
    bus.mem_ack = 1'b1;
    bad = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.mem_req || ld_wr || fault || stall) bad++;
    end
    chk("stray_ack", bad, 0);
    bus.mem_ack = 1'b0;

    // Async reset during REQ of a LW.
    @(negedge clk);
    inst_valid = 1'b1;
    opcode     = LD;
    func3      = 3'b010;
    addr_lo    = 2'd0;
    @(posedge clk); #1;
    inst_valid = 1'b0;
    chk("rst_mid_req_on", int'(bus.mem_req), 1);
    @(posedge clk); #3;
    rst        = 1'b0;
    inst_valid = 1'b1;
    #1;
    chk("rst_mid_req_drop", int'(bus.mem_req), 0);
    chk("rst_mid_stall", int'(stall), 0);
    @(negedge clk);
    @(negedge clk);
    rst        = 1'b1;
    inst_valid = 1'b0;
    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.mem_req || ld_wr || fault || stall) bad++;
    end
    chk("after_rst_quiet", bad, 0);
    run('{"sh_after_rst", ST, 3'b001, 2'd2, 1, 0, 4'b1100, 1'b1, 1, 0, 0, 2'b00, 2});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
